// File: rtl/display_scan_pkg.sv
// Shared types and sizing helpers for the multiplexed display scanner.
package display_scan_pkg;

   localparam int BRIGHT_W = 4;

   typedef logic [3:0] digit_t;

   function automatic int slot_w(input int slot_cycles);
      return $clog2(slot_cycles);
   endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot counter and digit index for the scan; exposes next-state values
// so the top level can register its outputs in step with the counter.
module scan_slot_timer
   import display_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SLOT_CYCLES = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [BRIGHT_W-1:0] bright,
   output logic [2:0]          idx_nxt,
   output logic                slot_end,
   output logic                frame_end,
   output logic                pwm_on
);

   localparam int SW = slot_w(SLOT_CYCLES);
   localparam logic [SW-1:0] CNT_MAX = SW'(SLOT_CYCLES - 1);
   localparam logic [2:0] IDX_TOP = 3'(NUM_DIGITS - 1);

   logic [SW-1:0] cnt;
   logic [SW-1:0] cnt_nxt;
   logic [2:0]    idx;

   always_comb begin
      slot_end  = en & (cnt == CNT_MAX);
      frame_end = slot_end & (idx == 3'd0);
      cnt_nxt   = '0;
      idx_nxt   = IDX_TOP;
      if (en) begin
         cnt_nxt = slot_end ? '0 : cnt + SW'(1);
         if (frame_end)
            idx_nxt = IDX_TOP;
         else if (slot_end)
            idx_nxt = idx - 3'd1;
         else
            idx_nxt = idx;
      end
      // count 0 is the guard cycle while the digit enables switch
      pwm_on = (cnt_nxt != '0) &
               (cnt_nxt[SW-1 -: BRIGHT_W] < bright);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= IDX_TOP;
      end else begin
         cnt <= cnt_nxt;
         idx <= idx_nxt;
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed N-digit scan controller driving one shared BCD decoder,
// with emulated leading-zero blanking, PWM brightness and frame-synced config.
module display_scan_controller
   import display_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SLOT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  wr_en_i,
   input  logic [2:0]            wr_addr_i,
   input  logic [3:0]            wr_data_i,
   input  logic [BRIGHT_W-1:0]   bright_i,
   input  logic                  lzb_en_i,
   input  logic                  lt_i,
   input  logic [2:0]            cfg_ver_i,
   input  logic [2:0]            cfg_tails_i,
   input  logic                  cfg_al_i,
   output logic [NUM_DIGITS-1:0] dig_en_o,
   output logic [3:0]            dec_value_o,
   output logic                  dec_rbi_o,
   output logic                  dec_bi_o,
   output logic                  dec_lt_o,
   output logic                  dec_al_o,
   output logic [2:0]            dec_ver_o,
   output logic [2:0]            dec_tails_o,
   output logic                  frame_o
);

   localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

   // sized for the full 3-bit address; entries >= NUM_DIGITS stay zero
   digit_t     dfile [8];
   logic       chain;
   logic       chain_nxt;
   logic       en_q;
   logic       cfg_lat;
   logic       slot_end;
   logic       frame_end;
   logic       pwm_on;
   logic [2:0] idx_nxt;

   scan_slot_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .SLOT_CYCLES (SLOT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .en        (en_i),
      .bright    (bright_i),
      .idx_nxt   (idx_nxt),
      .slot_end  (slot_end),
      .frame_end (frame_end),
      .pwm_on    (pwm_on)
   );

   always_comb begin
      cfg_lat   = frame_o | (en_i & ~en_q);
      chain_nxt = chain;
      if (cfg_lat)
         chain_nxt = ~lzb_en_i;
      else if (slot_end)
         chain_nxt = chain | (dec_value_o != 4'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++)
            dfile[i] <= '0;
         chain       <= 1'b1;
         en_q        <= 1'b0;
         dig_en_o    <= '0;
         dec_value_o <= '0;
         dec_rbi_o   <= 1'b1;
         dec_bi_o    <= 1'b0;
         dec_lt_o    <= 1'b1;
         dec_al_o    <= 1'b1;
         dec_ver_o   <= '0;
         dec_tails_o <= '0;
         frame_o     <= 1'b0;
      end else begin
         if (wr_en_i && (int'(wr_addr_i) < NUM_DIGITS))
            dfile[wr_addr_i] <= wr_data_i;
         en_q  <= en_i;
         chain <= chain_nxt;
         if (cfg_lat) begin
            dec_ver_o   <= cfg_ver_i;
            dec_tails_o <= cfg_tails_i;
            dec_al_o    <= cfg_al_i;
         end
         dig_en_o    <= en_i ? (DIG_ONE << idx_nxt) : '0;
         dec_value_o <= dfile[idx_nxt];
         // units digit is never blanked
         dec_rbi_o   <= (idx_nxt == 3'd0) | chain_nxt;
         dec_bi_o    <= en_i & pwm_on;
         dec_lt_o    <= ~lt_i;
         frame_o     <= frame_end;
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a frame-level
// model derived from the elapsed enabled-cycle count.
module tb_display_scan_controller;

   localparam int N = 4;
   localparam int S = 16;
   localparam int F = N * S;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         wr_en = 1'b0;
   logic [2:0]   wr_addr = '0;
   logic [3:0]   wr_data = '0;
   logic [3:0]   bright = '0;
   logic         lzb = 1'b0;
   logic         lt = 1'b0;
   logic [2:0]   ver = '0;
   logic [2:0]   tails = '0;
   logic         al = 1'b0;
   logic [N-1:0] dig_en;
   logic [3:0]   dec_value;
   logic         dec_rbi;
   logic         dec_bi;
   logic         dec_lt;
   logic         dec_al;
   logic [2:0]   dec_ver;
   logic [2:0]   dec_tails;
   logic         frame;

   int tests = 0;
   int fails = 0;
   int digs [N];
   int k;
   int lat_lzb;
   int lat_ver;
   int lat_tails;
   int lat_al;

   display_scan_controller #(
      .NUM_DIGITS  (N),
      .SLOT_CYCLES (S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .bright_i    (bright),
      .lzb_en_i    (lzb),
      .lt_i        (lt),
      .cfg_ver_i   (ver),
      .cfg_tails_i (tails),
      .cfg_al_i    (al),
      .dig_en_o    (dig_en),
      .dec_value_o (dec_value),
      .dec_rbi_o   (dec_rbi),
      .dec_bi_o    (dec_bi),
      .dec_lt_o    (dec_lt),
      .dec_al_o    (dec_al),
      .dec_ver_o   (dec_ver),
      .dec_tails_o (dec_tails),
      .frame_o     (frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (k=%0d)",
                  tag, got, exp, k);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".dig_en"}, dig_en, 0);
      check({tag, ".value"}, dec_value, 0);
      check({tag, ".rbi"}, dec_rbi, 1);
      check({tag, ".bi"}, dec_bi, 0);
      check({tag, ".lt"}, dec_lt, 1);
      check({tag, ".al"}, dec_al, 1);
      check({tag, ".ver"}, dec_ver, 0);
      check({tag, ".tails"}, dec_tails, 0);
      check({tag, ".frame"}, frame, 0);
   endtask

   // a digit is blanked only if every more significant digit is zero
   function automatic logic exp_rbi(input int i);
      if (i == 0 || lat_lzb == 0) return 1'b1;
      for (int j = i + 1; j < N; j++)
         if (digs[j] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic write_digit(input int a, input int d);
      wr_en = 1'b1;
      wr_addr = 3'(a);
      wr_data = 4'(d);
      @(posedge clk);
      if (a < N) digs[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // called at a negedge with en already high; k counts enabled edges
   task automatic run_checked(input int n, input int wk,
                              input int wa, input int wd);
      int ck;
      int idx;
      int c;
      int ev;
      ck = k + 2 + $urandom_range(0, 58);
      for (int i = 0; i < n; i++) begin
         if (k + 1 == wk) begin
            wr_en = 1'b1;
            wr_addr = 3'(wa);
            wr_data = 4'(wd);
         end
         if (k + 1 == ck) begin
            ver = 3'($urandom);
            tails = 3'($urandom);
            al = 1'($urandom);
         end
         @(posedge clk);
         k++;
         if (k % F == 1) begin
            lat_lzb = int'(lzb);
            lat_ver = int'(ver);
            lat_tails = int'(tails);
            lat_al = int'(al);
         end
         idx = N - 1 - (k / S) % N;
         c = k % S;
         ev = digs[idx];
         if (wr_en && int'(wr_addr) < N) digs[wr_addr] = int'(wr_data);
         @(negedge clk);
         wr_en = 1'b0;
         check("dig_en", dig_en, 1 << idx);
         check("value", dec_value, ev);
         check("bi", dec_bi,
               (c != 0 && (c / (S / 16)) < int'(bright)) ? 1 : 0);
         check("frame", frame, (k % F == 0) ? 1 : 0);
         if (c != 0) check("rbi", dec_rbi, exp_rbi(idx));
         check("ver", dec_ver, lat_ver);
         check("tails", dec_tails, lat_tails);
         check("al", dec_al, lat_al);
         check("lt", dec_lt, !lt);
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) digs[i] = 0;
      k = 0;
      repeat (3) @(negedge clk);
      check_reset("rst_hold");
      rst = 1'b0;
      en = 1'b1;
      bright = 4'd15;
      run_checked(40, -1, 0, 0);

      #2 rst = 1'b1;
      #1 check_reset("rst_async");
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < N; i++) digs[i] = 0;
      run_checked(70, -1, 0, 0);

      for (int it = 0; it < 9; it++) begin
         en = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("off.dig_en", dig_en, 0);
         check("off.bi", dec_bi, 0);
         check("off.frame", frame, 0);
         lzb = 1'($urandom);
         bright = 4'($urandom);
         lt = 1'($urandom);
         ver = 3'($urandom);
         tails = 3'($urandom);
         al = 1'($urandom);
         for (int a = 0; a < N; a++) begin
            int d;
            d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15);
            case (it)
               0: d = (a == 1) ? 4 : (a == 0) ? 2 : 0;
               1, 2: d = 0;
               default: ;
            endcase
            write_digit(a, d);
         end
         write_digit($urandom_range(N, 7), $urandom_range(1, 15));
         case (it)
            0: begin lzb = 1'b1; bright = 4'd15; end
            1: lzb = 1'b1;
            2: lzb = 1'b0;
            3: bright = 4'd8;
            4: bright = 4'd0;
            default: ;
         endcase
         en = 1'b1;
         k = 0;
         run_checked(2 * F, -1, 0, 0);
      end

      run_checked(40, k + 36, 1, 9);

      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("en_drop.dig_en", dig_en, 0);
      check("en_drop.bi", dec_bi, 0);
      en = 1'b1;
      k = 0;
      run_checked(20, -1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
